instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter NB, default 32, meaning data, address and PC width.
REQ-002 Parameter IMEM_DEPTH, default 256, meaning instruction memory words; word index width AW = clog2(IMEM_DEPTH).
REQ-003 i_clk  in  1  single clock, all state updates on rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_debug_mode  in  1  1 = step mode, 0 = continuous run.
REQ-006 i_step  in  1  one-cycle advance pulse, used only in step mode.
REQ-007 i_stall  in  1  hazard-unit freeze of the PC.
REQ-008 i_branch_taken  in  1  branch redirect request from a later stage.
REQ-009 i_branch_target  in  NB  branch destination byte address.
REQ-010 i_jump  in  1  jump redirect request from decode.
REQ-011 i_jump_target  in  NB  jump destination byte address.
REQ-012 i_imem_wr_en  in  1  debug-unit program-load write strobe.
REQ-013 i_imem_wr_addr  in  AW  word index to write.
REQ-014 i_imem_wr_data  in  NB  instruction word to write.
REQ-015 o_pc  out  NB  current fetch address.
REQ-016 o_pc4  out  NB  o_pc + 4, to the IF/ID register.
REQ-017 o_instruction  out  NB  word at o_pc, to the IF/ID register.
REQ-018 o_halt  out  1  sticky halt flag, also drives IF/ID flush.
REQ-019 o_fetch_count  out  NB  number of PC advances since reset.

Function
REQ-020 Advance enable SHALL be en = i_debug_mode ? i_step : 1.
REQ-021 Next-PC priority per rising edge SHALL be: reset > o_halt set > i_stall > (en & i_branch_taken) > (en & i_jump) > en (PC+4) > hold.
REQ-022 Redirect and advance SHALL occur only when en=1; a redirect without en is dropped, not queued.
REQ-023 Redirect targets SHALL be loaded with bits [1:0] forced to 0.
REQ-024 PC+4 SHALL wrap modulo 2^NB; memory index SHALL be o_pc[AW+1:2], so addresses beyond depth alias.
REQ-025 o_instruction SHALL be a combinational read of memory at o_pc, valid before the following falling edge.
REQ-026 o_pc4 SHALL be combinational o_pc + 4.
REQ-027 HALT word SHALL be 32'hFFFF_FFFF; when o_instruction equals HALT with en=1, i_stall=0 and i_branch_taken=0, o_halt SHALL set on that edge and the PC SHALL hold.
REQ-028 Branch taken in the same cycle as a HALT word SHALL win: PC redirects, o_halt stays 0.
REQ-029 Once set, o_halt SHALL remain 1 and the PC frozen until reset; stall, step and redirects are ignored.
REQ-030 o_fetch_count SHALL increment by 1 on every edge where the PC takes a new value (PC+4 or redirect), wrapping at 2^NB.
REQ-031 Memory writes SHALL take effect on the edge with i_imem_wr_en=1, at any time including reset and halt.
REQ-032 A write to the word currently at o_pc SHALL be visible on o_instruction after that edge.

Reset
REQ-033 On i_reset=1 at a rising edge: o_pc=0, o_halt=0, o_fetch_count=0; so o_pc4=4.
REQ-034 Reset SHALL NOT clear instruction memory contents.
REQ-035 Reset mid-redirect or mid-halt SHALL discard the redirect or halt.

Structure
REQ-036 Shared package SHALL hold HALT_INSTR, default NB and IMEM_DEPTH.
REQ-037 Memory SHALL be sub-module instruction_memory: one synchronous write port, one asynchronous read port.
REQ-038 PC register, halt flag and counter SHALL live in instruction_fetch.

Verification
REQ-039 Load words 0..3 = 0x20010001,0x20020002,0x20030003,0xFFFFFFFF, release reset, run continuous -> o_pc 0,4,8,12 then held at 12, o_halt=1, o_fetch_count=3.
REQ-040 Step mode, i_step pulsed twice 5 cycles apart -> o_pc changes 0->4->8 only on pulse edges, o_fetch_count=2.
REQ-041 At o_pc=8 assert i_branch_taken (target 0x41) and i_jump (target 0x80) together -> o_pc=0x40, o_fetch_count +1.
REQ-042 i_stall=1 with i_branch_taken=1 for 3 cycles -> o_pc unchanged; after release with no redirect -> o_pc+4.
REQ-043 HALT at o_pc=12 with i_branch_taken=1 target 0x100 -> o_pc=0x100, o_halt=0; later reset with o_halt=1 -> o_pc=0, o_halt=0, memory unchanged.
REQ-044 Write 0x12345678 to word 2 while o_pc=8 and stalled -> o_instruction=0x12345678 after that edge.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the instruction fetch stage: default widths and the HALT encoding.
package instruction_fetch_pkg;
   localparam int          NB_DEFAULT         = 32;
   localparam int          IMEM_DEPTH_DEFAULT = 256;
   localparam logic [31:0] HALT_INSTR         = 32'hFFFF_FFFF;
endpackage

// File: rtl/instruction_memory.sv
// Instruction store: one synchronous write port for program load, one asynchronous read port.
module instruction_memory
   import instruction_fetch_pkg::*;
#(
   parameter  int NB    = NB_DEFAULT,
   parameter  int DEPTH = IMEM_DEPTH_DEFAULT,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [NB-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [NB-1:0] rd_data
);

   logic [NB-1:0] mem_r [DEPTH];

   // Program-load write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register with stall/branch/jump/step control, sticky HALT detection
// and an advance counter, reading from a local instruction memory.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter  int NB         = NB_DEFAULT,
   parameter  int IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
   localparam int AW         = $clog2(IMEM_DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_debug_mode,
   input  logic          i_step,
   input  logic          i_stall,
   input  logic          i_branch_taken,
   input  logic [NB-1:0] i_branch_target,
   input  logic          i_jump,
   input  logic [NB-1:0] i_jump_target,
   input  logic          i_imem_wr_en,
   input  logic [AW-1:0] i_imem_wr_addr,
   input  logic [NB-1:0] i_imem_wr_data,
   output logic [NB-1:0] o_pc,
   output logic [NB-1:0] o_pc4,
   output logic [NB-1:0] o_instruction,
   output logic          o_halt,
   output logic [NB-1:0] o_fetch_count
);

   localparam logic [NB-1:0] WORD_MASK = ~NB'(32'd3);

   logic [NB-1:0] pc_r;
   logic [NB-1:0] pc_next_s;
   logic          halt_r;
   logic          halt_next_s;
   logic [NB-1:0] count_r;
   logic [NB-1:0] count_next_s;
   logic          en_s;
   logic          is_halt_s;
   logic [NB-1:0] pc4_s;

   instruction_memory #(
      .NB    (NB),
      .DEPTH (IMEM_DEPTH)
   ) u_imem (
      .clk     (i_clk),
      .wr_en   (i_imem_wr_en),
      .wr_addr (i_imem_wr_addr),
      .wr_data (i_imem_wr_data),
      .rd_addr (pc_r[AW+1:2]),
      .rd_data (o_instruction)
   );

   assign en_s      = i_debug_mode ? i_step : 1'b1;
   assign pc4_s     = pc_r + NB'(32'd4);
   assign is_halt_s = (o_instruction == NB'(HALT_INSTR));

   // Next-PC selection; HALT is checked after branch so a taken branch overrides it.
   always_comb begin
      pc_next_s    = pc_r;
      halt_next_s  = halt_r;
      count_next_s = count_r;
      if (halt_r) begin
         pc_next_s = pc_r;
      end else if (i_stall) begin
         pc_next_s = pc_r;
      end else if (en_s && i_branch_taken) begin
         pc_next_s    = i_branch_target & WORD_MASK;
         count_next_s = count_r + NB'(32'd1);
      end else if (en_s && is_halt_s) begin
         halt_next_s = 1'b1;
      end else if (en_s && i_jump) begin
         pc_next_s    = i_jump_target & WORD_MASK;
         count_next_s = count_r + NB'(32'd1);
      end else if (en_s) begin
         pc_next_s    = pc4_s;
         count_next_s = count_r + NB'(32'd1);
      end else begin
         pc_next_s = pc_r;
      end
   end

   // PC, halt flag and counter registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pc_r    <= '0;
         halt_r  <= 1'b0;
         count_r <= '0;
      end else begin
         pc_r    <= pc_next_s;
         halt_r  <= halt_next_s;
         count_r <= count_next_s;
      end
   end

   assign o_pc          = pc_r;
   assign o_pc4         = pc4_s;
   assign o_halt        = halt_r;
   assign o_fetch_count = count_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch: continuous run to HALT, step mode,
// redirect priority, stall, PC wrap, live memory writes and reset behaviour.
module tb_instruction_fetch;
   localparam int NB = 32;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset, debug_mode, step, stall, branch_taken, jump, imem_wr_en;
   logic [NB-1:0] branch_target, jump_target, imem_wr_data;
   logic [AW-1:0] imem_wr_addr;
   logic [NB-1:0] pc, pc4, instruction, fetch_count;
   logic          halt;

   int n_assert = 0;
   int n_fail   = 0;

   instruction_fetch #(.NB(NB), .IMEM_DEPTH(256)) dut (
      .i_clk           (clk),
      .i_reset         (reset),
      .i_debug_mode    (debug_mode),
      .i_step          (step),
      .i_stall         (stall),
      .i_branch_taken  (branch_taken),
      .i_branch_target (branch_target),
      .i_jump          (jump),
      .i_jump_target   (jump_target),
      .i_imem_wr_en    (imem_wr_en),
      .i_imem_wr_addr  (imem_wr_addr),
      .i_imem_wr_data  (imem_wr_data),
      .o_pc            (pc),
      .o_pc4           (pc4),
      .o_instruction   (instruction),
      .o_halt          (halt),
      .o_fetch_count   (fetch_count)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_assert++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [AW-1:0] load_idx  [10] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd16, 8'd17, 8'd32, 8'd64, 8'd65, 8'd255};
   logic [NB-1:0] load_data [10] = '{32'h2001_0001, 32'h2002_0002, 32'h2003_0003, 32'hFFFF_FFFF,
                                     32'h0000_0013, 32'h0000_0093, 32'h0000_0113, 32'h0000_0033,
                                     32'h0000_00B3, 32'h0000_0001};

   initial begin
      reset = 1'b1; debug_mode = 1'b0; step = 1'b0; stall = 1'b0;
      branch_taken = 1'b0; jump = 1'b0; branch_target = '0; jump_target = '0;
      imem_wr_en = 1'b0; imem_wr_addr = '0; imem_wr_data = '0;

      // program load while held in reset
      for (int i = 0; i < 10; i++) begin
         imem_wr_en = 1'b1; imem_wr_addr = load_idx[i]; imem_wr_data = load_data[i];
         tick();
      end
      imem_wr_en = 1'b0;
      check_value("rst_pc", pc, 32'h0);
      check_value("rst_pc4", pc4, 32'h4);
      check_value("rst_halt", {31'd0, halt}, 32'h0);
      check_value("rst_cnt", fetch_count, 32'h0);
      check_value("rst_instr", instruction, 32'h2001_0001);

      // continuous run into HALT
      reset = 1'b0;
      tick(); check_value("run_pc1", pc, 32'h4);
      tick(); check_value("run_pc2", pc, 32'h8);
      check_value("run_instr2", instruction, 32'h2003_0003);
      tick(); check_value("run_pc3", pc, 32'hC);
      check_value("run_instr3", instruction, 32'hFFFF_FFFF);
      check_value("run_halt_pre", {31'd0, halt}, 32'h0);
      tick(); check_value("halt_pc", pc, 32'hC);
      check_value("halt_flag", {31'd0, halt}, 32'h1);
      check_value("halt_cnt", fetch_count, 32'h3);
      branch_taken = 1'b1; branch_target = 32'h100;
      tick(); check_value("halt_ign_br_pc", pc, 32'hC);
      check_value("halt_sticky", {31'd0, halt}, 32'h1);
      branch_taken = 1'b0;

      // reset out of halt
      reset = 1'b1; tick(); reset = 1'b0;
      check_value("rst2_pc", pc, 32'h0);
      check_value("rst2_halt", {31'd0, halt}, 32'h0);
      check_value("rst2_cnt", fetch_count, 32'h0);

      // step mode
      debug_mode = 1'b1;
      tick(); tick(); tick();
      check_value("step_idle_pc", pc, 32'h0);
      step = 1'b1; tick(); step = 1'b0;
      check_value("step1_pc", pc, 32'h4);
      tick(); tick(); tick(); tick();
      check_value("step_wait_pc", pc, 32'h4);
      step = 1'b1; tick(); step = 1'b0;
      check_value("step2_pc", pc, 32'h8);
      check_value("step2_cnt", fetch_count, 32'h2);
      branch_taken = 1'b1; branch_target = 32'h41;
      tick(); check_value("br_no_en_pc", pc, 32'h8);
      branch_taken = 1'b0;
      tick(); check_value("br_not_queued", pc, 32'h8);
      check_value("br_no_en_cnt", fetch_count, 32'h2);
      branch_taken = 1'b1; branch_target = 32'h41; jump = 1'b1; jump_target = 32'h80; step = 1'b1;
      tick(); step = 1'b0; branch_taken = 1'b0; jump = 1'b0;
      check_value("br_over_jmp_pc", pc, 32'h40);
      check_value("br_over_jmp_cnt", fetch_count, 32'h3);

      // continuous with stall, jump and PC wrap
      debug_mode = 1'b0; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
      tick(); tick(); tick();
      check_value("stall_pc", pc, 32'h40);
      check_value("stall_cnt", fetch_count, 32'h3);
      stall = 1'b0; branch_taken = 1'b0;
      tick(); check_value("unstall_pc", pc, 32'h44);
      check_value("unstall_cnt", fetch_count, 32'h4);
      jump = 1'b1; jump_target = 32'h83;
      tick(); check_value("jmp_align_pc", pc, 32'h80);
      jump_target = 32'hFFFF_FFFF;
      tick(); check_value("wrap_pc", pc, 32'hFFFF_FFFC);
      check_value("wrap_pc4", pc4, 32'h0);
      check_value("wrap_instr", instruction, 32'h0000_0001);
      jump = 1'b0;
      tick(); check_value("wrap_next_pc", pc, 32'h0);
      check_value("wrap_cnt", fetch_count, 32'h7);

      // live memory write while stalled, branch beats HALT
      reset = 1'b1; tick(); reset = 1'b0;
      tick(); tick();
      check_value("f_pc8", pc, 32'h8);
      stall = 1'b1; imem_wr_en = 1'b1; imem_wr_addr = 8'd2; imem_wr_data = 32'h1234_5678;
      tick(); check_value("wr_vis_instr", instruction, 32'h1234_5678);
      check_value("wr_vis_pc", pc, 32'h8);
      imem_wr_data = 32'h2003_0003;
      tick(); imem_wr_en = 1'b0; stall = 1'b0;
      check_value("wr_restore", instruction, 32'h2003_0003);
      tick(); check_value("f_pc12", pc, 32'hC);
      branch_taken = 1'b1; branch_target = 32'h100;
      tick(); branch_taken = 1'b0;
      check_value("br_halt_pc", pc, 32'h100);
      check_value("br_halt_flag", {31'd0, halt}, 32'h0);
      check_value("br_halt_cnt", fetch_count, 32'h4);
      jump = 1'b1; jump_target = 32'hC;
      tick(); jump = 1'b0;
      check_value("back12_pc", pc, 32'hC);
      tick(); check_value("halt2_flag", {31'd0, halt}, 32'h1);
      check_value("halt2_cnt", fetch_count, 32'h5);
      debug_mode = 1'b1; step = 1'b1; branch_taken = 1'b1; branch_target = 32'h0;
      tick(); check_value("halt2_frozen", pc, 32'hC);
      debug_mode = 1'b0; step = 1'b0; branch_taken = 1'b0;

      // reset from halt keeps memory
      reset = 1'b1; tick(); reset = 1'b0;
      check_value("rst3_pc", pc, 32'h0);
      check_value("rst3_halt", {31'd0, halt}, 32'h0);
      check_value("rst3_instr", instruction, 32'h2001_0001);
      tick(); tick(); tick();
      check_value("rst3_word3", instruction, 32'hFFFF_FFFF);
      check_value("rst3_pc12", pc, 32'hC);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
